// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch FSM encoding, program terminator
// and the opcode map used by decode/execute.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [2:0] FS_IDLE   = 3'd0;
  localparam logic [2:0] FS_FETCH  = 3'd1;
  localparam logic [2:0] FS_WAIT   = 3'd2;
  localparam logic [2:0] FS_HOLD   = 3'd3;
  localparam logic [2:0] FS_HALTED = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = FS_IDLE,
    ST_FETCH  = FS_FETCH,
    ST_WAIT   = FS_WAIT,
    ST_HOLD   = FS_HOLD,
    ST_HALTED = FS_HALTED
  } fetch_state_t;

  localparam logic [INSTR_W-1:0] END_OF_PROG = 16'h0000;

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_CPL = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_MVI = 4'b1100;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch controller for the synchronous program ROM: start to first instr_valid is 3 cycles,
// 1 word per 3 cycles; the word is held in HOLD until instr_ready, nothing is fetched meanwhile.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = cpu_pkg::ADDR_W,
  parameter int                INSTR_W    = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               rom_read,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        retired_cnt
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              halt_pend;
  logic              handshake;
  logic              word_is_end;

  assign rom_read    = (state == ST_FETCH);
  assign rom_addr    = pc;
  assign instr_valid = (state == ST_HOLD);
  assign busy        = (state == ST_FETCH) || (state == ST_WAIT) || (state == ST_HOLD);
  assign halted      = (state == ST_HALTED);
  assign handshake   = instr_valid && instr_ready;
  assign word_is_end = (rom_data == INSTR_W'(END_OF_PROG));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = redirect_valid ? ST_FETCH : ST_WAIT;
      ST_WAIT: begin
        if (redirect_valid)   state_nxt = ST_FETCH;
        else if (word_is_end) state_nxt = ST_HALTED;
        else                  state_nxt = ST_HOLD;
      end
      // A redirect wins over a pending halt; the halt waits for the next accepted word.
      ST_HOLD: begin
        if (redirect_valid) state_nxt = ST_FETCH;
        else if (handshake) state_nxt = halt_pend ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: if (start) state_nxt = ST_FETCH;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= START_ADDR;
      halt_pend   <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      retired_cnt <= '0;
    end else begin
      state <= state_nxt;

      if (handshake && (retired_cnt != 16'hFFFF))
        retired_cnt <= retired_cnt + 16'd1;

      if (busy && redirect_valid)
        pc <= redirect_addr;
      else if ((state == ST_IDLE) && start)
        pc <= START_ADDR;
      else if ((state == ST_WAIT) && !word_is_end) begin
        pc        <= pc + 1'b1;
        instr_out <= rom_data;
        instr_pc  <= pc;
      end

      if (state == ST_HALTED)
        halt_pend <= 1'b0;
      else if (busy && halt_req)
        halt_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios on two instances (START_ADDR 00 and FE)
// plus a randomized run scored against a transaction-level reference model.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance 0: START_ADDR = 00
  logic        start0 = 0, halt0 = 0, redir_v0 = 0, rdy0 = 0;
  logic [7:0]  redir_a0 = 0, addr0, ipc0;
  logic        rd0, vld0, busy0, hlt0;
  logic [15:0] data0 = 0, out0, cnt0;
  logic [15:0] rom0 [256];

  // instance 1: START_ADDR = FE
  logic        start1 = 0, rdy1 = 1;
  logic [7:0]  addr1, ipc1;
  logic        rd1, vld1, busy1, hlt1;
  logic [15:0] data1 = 0, out1, cnt1;
  logic [15:0] rom1 [256];

  fetch_sequencer #(.START_ADDR(8'h00)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .halt_req(halt0),
    .redirect_valid(redir_v0), .redirect_addr(redir_a0),
    .rom_read(rd0), .rom_addr(addr0), .rom_data(data0),
    .instr_valid(vld0), .instr_ready(rdy0), .instr_out(out0), .instr_pc(ipc0),
    .busy(busy0), .halted(hlt0), .retired_cnt(cnt0)
  );

  fetch_sequencer #(.START_ADDR(8'hFE)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .halt_req(1'b0),
    .redirect_valid(1'b0), .redirect_addr(8'h00),
    .rom_read(rd1), .rom_addr(addr1), .rom_data(data1),
    .instr_valid(vld1), .instr_ready(rdy1), .instr_out(out1), .instr_pc(ipc1),
    .busy(busy1), .halted(hlt1), .retired_cnt(cnt1)
  );

  // synchronous ROMs: data valid the cycle after the read strobe
  always @(posedge clk) if (rd0) data0 <= rom0[addr0];
  always @(posedge clk) if (rd1) data1 <= rom1[addr1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 0; start0 = 0; start1 = 0; halt0 = 0; redir_v0 = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_vld(input int which, inout int n);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      n++;
      seen = (which != 0) ? vld1 : vld0;
    end
    chk("vld_seen", 32'(seen), 1);
  endtask

  task automatic wait_halt0();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = hlt0;
    end
    chk("halt_seen", 32'(seen), 1);
  endtask

  task automatic pulse_start0();
    start0 = 1;
    @(negedge clk);
    start0 = 0;
  endtask

  // reference model state for the random run
  int          nxt;
  int          exp_cnt;
  bit          running, hpend, hs, rdir;
  logic [7:0]  raddr;

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      rom0[i] = 16'h1000 + 16'(i);
      rom1[i] = 16'h2000 + 16'(i);
    end
    rom0[0] = 16'hC041; rom0[1] = 16'hC082; rom0[2] = 16'h0000;

    // basic program: reset values, latency, two words, terminator
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_vld", 32'(vld0), 0);   chk("rst_rd", 32'(rd0), 0);
    chk("rst_busy", 32'(busy0), 0); chk("rst_halted", 32'(hlt0), 0);
    chk("rst_out", 32'(out0), 0);   chk("rst_ipc", 32'(ipc0), 0);
    chk("rst_cnt", 32'(cnt0), 0);
    rst_n = 1;
    rdy0 = 1;
    @(negedge clk);
    pulse_start0();
    n = 1;
    chk("t1_rd_c1", 32'(rd0), 1);
    chk("t1_addr_c1", 32'(addr0), 0);
    wait_vld(0, n);
    chk("t1_latency", 32'(n), 3);
    chk("t1_out0", 32'(out0), 32'hC041); chk("t1_pc0", 32'(ipc0), 0);
    n = 0;
    wait_vld(0, n);
    chk("t1_out1", 32'(out0), 32'hC082); chk("t1_pc1", 32'(ipc0), 1);
    chk("t1_gap", 32'(n), 3);
    wait_halt0();
    chk("t1_cnt", 32'(cnt0), 2);
    chk("t1_pc_end", 32'(addr0), 2);
    chk("t1_busy_end", 32'(busy0), 0);

    // consumer stall in HOLD
    do_reset();
    rdy0 = 0;
    pulse_start0();
    n = 1;
    wait_vld(0, n);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_out", 32'(out0), 32'hC041);
      chk("t2_rd", 32'(rd0), 0);
      chk("t2_cnt", 32'(cnt0), 0);
      chk("t2_vld", 32'(vld0), 1);
    end
    rdy0 = 1;
    @(negedge clk);
    chk("t2_cnt_after", 32'(cnt0), 1);
    chk("t2_vld_after", 32'(vld0), 0);

    // redirect during WAIT of address 00
    do_reset();
    rdy0 = 1;
    pulse_start0();              // now in FETCH of 00
    @(negedge clk);              // now in WAIT of 00
    redir_v0 = 1; redir_a0 = 8'h01;
    @(negedge clk);
    redir_v0 = 0;
    chk("t3_addr", 32'(addr0), 1);
    chk("t3_rd", 32'(rd0), 1);
    chk("t3_vld", 32'(vld0), 0);
    n = 0;
    wait_vld(0, n);
    chk("t3_out", 32'(out0), 32'hC082);
    chk("t3_pc", 32'(ipc0), 1);

    // halt request in FETCH of 00, then resume
    do_reset();
    rdy0 = 1;
    pulse_start0();
    halt0 = 1;
    @(negedge clk);
    halt0 = 0;
    n = 0;
    wait_vld(0, n);
    chk("t4_out", 32'(out0), 32'hC041);
    @(negedge clk);
    chk("t4_halted", 32'(hlt0), 1);
    chk("t4_pc", 32'(addr0), 1);
    chk("t4_cnt", 32'(cnt0), 1);
    pulse_start0();
    chk("t4_resume_rd", 32'(rd0), 1);
    chk("t4_resume_addr", 32'(addr0), 1);

    // handshake and redirect in the same HOLD cycle
    do_reset();
    rdy0 = 0;
    pulse_start0();
    n = 1;
    wait_vld(0, n);
    rdy0 = 1; redir_v0 = 1; redir_a0 = 8'h05;
    @(negedge clk);
    redir_v0 = 0;
    chk("t6_cnt", 32'(cnt0), 1);
    chk("t6_addr", 32'(addr0), 5);
    chk("t6_rd", 32'(rd0), 1);

    // START_ADDR FE wraps to 00; reset mid-WAIT
    do_reset();
    rdy0 = 0;
    chk("t5_rst_addr", 32'(addr1), 32'hFE);
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    n = 1;
    wait_vld(1, n);
    chk("t5_pc_fe", 32'(ipc1), 32'hFE); chk("t5_out_fe", 32'(out1), 32'h20FE);
    wait_vld(1, n);
    chk("t5_pc_ff", 32'(ipc1), 32'hFF);
    wait_vld(1, n);
    chk("t5_pc_00", 32'(ipc1), 32'h00); chk("t5_out_00", 32'(out1), 32'h2000);
    @(negedge clk);
    chk("t5_fetch_rd", 32'(rd1), 1);
    @(negedge clk);
    chk("t5_wait_busy", 32'(busy1), 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("t5_r_vld", 32'(vld1), 0);   chk("t5_r_rd", 32'(rd1), 0);
    chk("t5_r_busy", 32'(busy1), 0); chk("t5_r_halted", 32'(hlt1), 0);
    chk("t5_r_out", 32'(out1), 0);   chk("t5_r_ipc", 32'(ipc1), 0);
    chk("t5_r_cnt", 32'(cnt1), 0);   chk("t5_r_addr", 32'(addr1), 32'hFE);

    // randomized run: no terminators, random ready/redirect/halt/restart
    for (int i = 0; i < 256; i++) rom0[i] = 16'($urandom_range(1, 16'hFFFF));
    do_reset();
    rdy0 = 0;
    pulse_start0();
    nxt = 0; exp_cnt = 0; running = 1; hpend = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("r_busy", 32'(busy0), 32'(running));
      chk("r_halted", 32'(hlt0), 32'(!running));
      chk("r_cnt", 32'(cnt0), 32'(exp_cnt));
      rdy0     = 1'($urandom_range(0, 1));
      rdir     = running && ($urandom_range(0, 11) == 0);
      raddr    = 8'($urandom_range(0, 255));
      redir_v0 = rdir;
      redir_a0 = raddr;
      halt0    = running && !rdir && !rdy0 && ($urandom_range(0, 39) == 0);
      start0   = !running && ($urandom_range(0, 3) == 0);
      hs = running && vld0 && rdy0;
      if (hs) begin
        chk("r_pc", 32'(ipc0), 32'(nxt));
        chk("r_word", 32'(out0), 32'(rom0[nxt]));
        exp_cnt++;
        nxt = (nxt + 1) % 256;
      end
      if (halt0) hpend = 1;
      if (rdir) nxt = int'(raddr);
      else if (hs && hpend) begin
        running = 0;
        hpend = 0;
      end
      if (start0) running = 1;
      @(negedge clk);
    end
    rdy0 = 0; redir_v0 = 0; halt0 = 0; start0 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
